icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache_if.sv | 11 +
 rtl/icache.sv | 109 ++++++++++
 tb/tb_icache.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/icache_if.sv
// External instruction-memory read bus between the icache (master) and memory (slave).
// One word is requested at a time; each acknowledge returns one word.
interface icache_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_ack;

    modport master (output mem_req, output mem_addr, input mem_data, input mem_ack);
    modport slave  (input mem_req, input mem_addr, output mem_data, output mem_ack);
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache: 2**INDEX_W lines of four words each, zero-cycle hit,
// in-order four-word refill on a miss, with the pipeline stalled until the line is installed.
module icache #(
    parameter int INDEX_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic [31:0] addr_i,
    output logic [31:0] inst_o,
    output logic        stallreq_o,
    icache_if.master    mem
);
    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = 28 - INDEX_W;

    typedef enum logic [1:0] {IDLE = 2'd0, REFILL = 2'd1, DONE = 2'd2} state_t;

    state_t             state_r;
    logic [LINES-1:0]   valid_r;
    logic [TAG_W-1:0]   tag_r  [LINES];
    logic [31:0]        data_r [LINES*4];
    logic [27:0]        line_r;
    logic [1:0]         cnt_r;

    logic [1:0]         offset_s;
    logic [INDEX_W-1:0] index_s;
    logic [TAG_W-1:0]   tag_s;
    logic [INDEX_W-1:0] fill_index_s;
    logic               hit_s;
    logic               ack_s;

    assign offset_s     = addr_i[3:2];
    assign index_s      = addr_i[INDEX_W+3:4];
    assign tag_s        = addr_i[31:INDEX_W+4];
    assign fill_index_s = line_r[INDEX_W-1:0];
    assign ack_s        = (state_r == REFILL) && mem.mem_ack;

    // Lookup: only an idle cache can hit; a refill in flight always stalls.
    always_comb begin
        hit_s = ce_i && valid_r[index_s] && (tag_r[index_s] == tag_s) && (state_r == IDLE);
    end

    // Outputs are forced quiet while reset is held, even mid-refill.
    always_comb begin
        inst_o       = 32'd0;
        stallreq_o   = 1'b0;
        mem.mem_req  = 1'b0;
        mem.mem_addr = 32'd0;
        if (!rst) begin
            if (hit_s) begin
                inst_o = data_r[{index_s, offset_s}];
            end else begin
                inst_o = 32'd0;
            end
            stallreq_o  = (state_r != IDLE) || (ce_i && !hit_s);
            mem.mem_req = (state_r == REFILL);
            if (state_r == REFILL) begin
                mem.mem_addr = {line_r, cnt_r, 2'b00};
            end else begin
                mem.mem_addr = 32'd0;
            end
        end else begin
            inst_o = 32'd0;
        end
    end

    // Refill controller: latches the missing line and walks words 0..3 on acknowledges.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            valid_r <= '0;
            line_r  <= 28'd0;
            cnt_r   <= 2'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ce_i && !hit_s) begin
                        line_r           <= addr_i[31:4];
                        cnt_r            <= 2'd0;
                        valid_r[index_s] <= 1'b0;
                        state_r          <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem.mem_ack) begin
                        cnt_r <= cnt_r + 2'd1;
                        if (cnt_r == 2'd3) begin
                            valid_r[fill_index_s] <= 1'b1;
                            state_r               <= DONE;
                        end
                    end
                end
                DONE:    state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    // Data and tag storage carry no reset; the valid bits alone qualify their contents.
    always_ff @(posedge clk) begin
        if (!rst && ack_s) begin
            data_r[{fill_index_s, cnt_r}] <= mem.mem_data;
            if (cnt_r == 2'd3) begin
                tag_r[fill_index_s] <= line_r[27:INDEX_W];
            end
        end
    end
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a line-level cache model checks every cycle, and each scenario
// pins stall lengths, fetched words and refill addresses against hand-computed values.
module tb_icache;
    logic        clk = 1'b0;
    logic        rst;
    logic        ce_i;
    logic [31:0] addr_i;
    logic [31:0] inst_o;
    logic        stallreq_o;

    icache_if mif ();

    icache #(.INDEX_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .ce_i       (ce_i),
        .addr_i     (addr_i),
        .inst_o     (inst_o),
        .stallreq_o (stallreq_o),
        .mem        (mif)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int delay = 0;
    int wcnt  = 0;
    bit stray = 1'b0;
    logic [31:0] addr_log [$];

    // Model: which lines are resident, and the progress of any refill in flight.
    bit          m_valid [16];
    logic [23:0] m_tag   [16];
    bit          m_busy = 1'b0;
    bit          m_post = 1'b0;
    logic [27:0] m_line = 28'd0;
    int          m_words = 0;
    logic [31:0] e_inst;
    logic [31:0] e_addr;
    logic        e_stall;
    logic        e_req;
    bit          m_idle;
    bit          m_hit;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return 32'h0000_1000 + {2'b00, a[31:2]};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory: acknowledges each requested word after `delay` wait cycles; `stray` forces a bogus ack.
    always begin
        @(negedge clk);
        #1;
        if (stray) begin
            mif.mem_ack  = 1'b1;
            mif.mem_data = 32'hDEAD_BEEF;
        end else if (mif.mem_req === 1'b1) begin
            if (wcnt >= delay) begin
                mif.mem_ack  = 1'b1;
                mif.mem_data = memword(mif.mem_addr);
                wcnt         = 0;
            end else begin
                mif.mem_ack  = 1'b0;
                mif.mem_data = 32'd0;
                wcnt++;
            end
        end else begin
            mif.mem_ack  = 1'b0;
            mif.mem_data = 32'd0;
            wcnt         = 0;
        end
    end

    // Per-cycle comparison against the model, then advance the model across the coming edge.
    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            check("rst inst", inst_o, 32'd0);
            check("rst stall", {31'd0, stallreq_o}, 32'd0);
            check("rst req", {31'd0, mif.mem_req}, 32'd0);
            check("rst addr", mif.mem_addr, 32'd0);
            for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
            m_busy = 1'b0;
            m_post = 1'b0;
        end else begin
            m_idle  = !m_busy && !m_post;
            m_hit   = m_idle && ce_i && m_valid[addr_i[7:4]] && (m_tag[addr_i[7:4]] == addr_i[31:8]);
            e_inst  = m_hit ? memword(addr_i) : 32'd0;
            e_stall = !m_idle || (ce_i && !m_hit);
            e_req   = m_busy;
            e_addr  = m_busy ? {m_line, 4'd0} + 32'(m_words * 4) : 32'd0;
            check("inst", inst_o, e_inst);
            check("stall", {31'd0, stallreq_o}, {31'd0, e_stall});
            check("req", {31'd0, mif.mem_req}, {31'd0, e_req});
            check("addr", mif.mem_addr, e_addr);
            if (mif.mem_req === 1'b1 && mif.mem_ack === 1'b1) addr_log.push_back(mif.mem_addr);
            if (m_post) begin
                m_post = 1'b0;
            end else if (m_busy) begin
                if (mif.mem_ack === 1'b1) begin
                    m_words++;
                    if (m_words == 4) begin
                        m_busy = 1'b0;
                        m_post = 1'b1;
                        m_valid[m_line[3:0]] = 1'b1;
                        m_tag[m_line[3:0]]   = m_line[27:4];
                    end
                end
            end else if (ce_i && !m_hit) begin
                m_busy  = 1'b1;
                m_line  = addr_i[31:4];
                m_words = 0;
                m_valid[addr_i[7:4]] = 1'b0;
            end
        end
    end

    // Present address `a` until the stall drops; check the stall length and the word delivered.
    task automatic fetch(input string nm, input logic [31:0] a, input int exp_stall,
                         input logic [31:0] exp_inst);
        int  n    = 0;
        bit  done = 1'b0;
        while (!done) begin
            @(negedge clk);
            rst    = 1'b0;
            ce_i   = 1'b1;
            addr_i = a;
            #3;
            if (!stallreq_o) begin
                done = 1'b1;
            end else begin
                n++;
                if (n > 200) done = 1'b1;
            end
        end
        check({nm, " stall cycles"}, 32'(n), 32'(exp_stall));
        check({nm, " inst"}, inst_o, exp_inst);
    endtask

    initial begin
        rst    = 1'b1;
        ce_i   = 1'b1;
        addr_i = 32'h0000_0010;
        repeat (2) @(negedge clk);

        addr_log.delete();
        fetch("cold miss", 32'h0000_0010, 6, 32'h0000_1004);
        check("cold refill words", 32'(addr_log.size()), 32'd4);
        if (addr_log.size() == 4) begin
            check("cold w0 addr", addr_log[0], 32'h0000_0010);
            check("cold w1 addr", addr_log[1], 32'h0000_0014);
            check("cold w2 addr", addr_log[2], 32'h0000_0018);
            check("cold w3 addr", addr_log[3], 32'h0000_001C);
        end

        fetch("hit 14", 32'h0000_0014, 0, 32'h0000_1005);
        fetch("hit 18", 32'h0000_0018, 0, 32'h0000_1006);
        fetch("hit 1C", 32'h0000_001C, 0, 32'h0000_1007);

        fetch("conflict 110", 32'h0000_0110, 6, 32'h0000_1044);
        fetch("evicted 10", 32'h0000_0010, 6, 32'h0000_1004);

        delay = 3;
        fetch("slow 30", 32'h0000_0030, 18, 32'h0000_100C);
        delay = 0;
        fetch("slow line 34", 32'h0000_0034, 0, 32'h0000_100D);

        addr_log.delete();
        repeat (3) begin
            @(negedge clk);
            rst    = 1'b0;
            ce_i   = 1'b1;
            addr_i = 32'h0000_0020;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        ce_i  = 1'b0;
        stray = 1'b1;
        #3;
        check("abort req", {31'd0, mif.mem_req}, 32'd0);
        check("abort stall", {31'd0, stallreq_o}, 32'd0);
        check("abort words", 32'(addr_log.size()), 32'd2);
        @(negedge clk);
        stray = 1'b0;
        fetch("refetch 20", 32'h0000_0020, 6, 32'h0000_1008);

        repeat (3) begin
            @(negedge clk);
            ce_i   = 1'b0;
            addr_i = 32'h0000_0040;
            #3;
            check("ce0 inst", inst_o, 32'd0);
            check("ce0 stall", {31'd0, stallreq_o}, 32'd0);
            check("ce0 req", {31'd0, mif.mem_req}, 32'd0);
        end

        addr_log.delete();
        @(negedge clk);
        ce_i   = 1'b1;
        addr_i = 32'h0000_0050;
        fetch("moved addr 60", 32'h0000_0060, 11, 32'h0000_1018);
        if (addr_log.size() == 8) check("moved w0 addr", addr_log[0], 32'h0000_0050);
        else check("moved refill words", 32'(addr_log.size()), 32'd8);
        fetch("kept line 50", 32'h0000_0050, 0, 32'h0000_1014);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
